fifo_stream_reader: RTL

- Read-side companion to the team's synchronous FIFO: drains FIFO words and presents them as a valid/ready stream to a downstream consumer.
- Issues FIFO read enables, tracks reads still in flight across the FIFO's fixed read latency, and captures returning data into a small skid buffer.
- The credit rule means no returning word is ever lost under back-pressure, and full throughput is kept when the consumer is always ready.

---
 rtl/fifo_stream_reader.sv | 118 +++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a fixed-latency synchronous FIFO into a valid/ready stream.
// A credit check on skid space plus in-flight reads keeps returning words from being dropped.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int RD_LATENCY  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata_i,
  input  logic                   flush_i,
  output logic                   m_valid_o,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  input  logic                   m_ready_i,
  output logic [COUNT_WIDTH-1:0] cnt_o,
  output logic                   busy_o
);

  localparam int SKID_DEPTH = RD_LATENCY + 2;
  localparam int SKID_AW    = $clog2(SKID_DEPTH) + 1;
  localparam int PTR_W      = $clog2(SKID_DEPTH);

  localparam logic [PTR_W-1:0]   L_LAST  = PTR_W'(SKID_DEPTH - 1);
  localparam logic [SKID_AW:0]   L_DEPTH = (SKID_AW + 1)'(SKID_DEPTH);
  localparam logic [SKID_AW-1:0] L_ONE   = SKID_AW'(1);

  logic [DATA_WIDTH-1:0]  r_skid [SKID_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [SKID_AW-1:0]     r_occ;
  logic [RD_LATENCY-1:0]  r_pipe;
  logic [COUNT_WIDTH-1:0] r_cnt;

  logic [SKID_AW-1:0] w_inflight;
  logic [SKID_AW:0]   w_used;
  logic               w_rd_en;
  logic               w_capture;
  logic               w_valid;
  logic               w_hs;

  function automatic logic [PTR_W-1:0] next_ptr(
    input logic [PTR_W-1:0] p
  );
    return (p == L_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      w_inflight = w_inflight + SKID_AW'(r_pipe[i]);
  end

  assign w_used  = {1'b0, r_occ} + {1'b0, w_inflight};
  assign w_valid = (r_occ != '0);
  assign w_hs    = w_valid && m_ready_i;

  // Credits cover both stored and still-returning words.
  assign w_rd_en = !rst_i && !fifo_empty_i && !flush_i &&
                   (w_used < L_DEPTH);

  assign w_capture = r_pipe[RD_LATENCY-1] && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pipe <= '0;
    end else if (flush_i) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_rd_en;
      for (int i = 1; i < RD_LATENCY; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_capture)
      r_skid[r_wr_ptr] <= fifo_rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_capture)
        r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_hs)
        r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_capture, w_hs})
        2'b10:   r_occ <= r_occ + L_ONE;
        2'b01:   r_occ <= r_occ - L_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A handshake in the flush cycle still completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_cnt <= '0;
    else if (w_hs)
      r_cnt <= r_cnt + 1'b1;
  end

  assign fifo_rd_en_o = w_rd_en;
  assign m_valid_o    = w_valid;
  assign m_data_o     = w_valid ? r_skid[r_rd_ptr] : '0;
  assign cnt_o        = r_cnt;
  assign busy_o       = w_valid || (|r_pipe);

endmodule
